uart_dbg_responder: RTL and testbench
=====================================

Name: uart_dbg_responder

Overview:
- Command responder on the byte side of the UART transceiver: consumes rx_data/rx_done, drives tx_data/tx_wr.
- Decodes host read/write commands and runs one 32-bit access on a simple req/ack memory bus.
- Returns the result as response bytes.
- Lets a host PC peek and poke SoC memory over the serial link without CPU involvement.

Parameters:
- TIMEOUT_CYCLES, 24'd10_000_000: inter-byte timeout in sys_clk cycles while a command is partially received.
- BUS_TIMEOUT, 16'd1024: maximum cycles mem_req may wait for mem_ack.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous active-high reset.
- rx_data  in  8  received byte from transceiver.
- rx_done  in  1  one-cycle strobe; rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_wr  out  1  one-cycle transmit strobe.
- tx_done  in  1  one-cycle strobe; transmitted byte finished.
- mem_addr  out  32  bus address, word aligned (bits [1:0] forced 0).
- mem_wdata  out  32  bus write data.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_req  out  1  bus request, level.
- mem_ack  in  1  one-cycle completion strobe.
- mem_rdata  in  32  read data, valid with mem_ack.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on timeout, bad opcode or bus timeout.

Behaviour:
- Reset (async, immediate): state IDLE; tx_data=0, tx_wr=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_req=0, busy=0, err=0; counters cleared. Reset mid-transfer drops mem_req in the same instant; the command is discarded.
- Command format. Write: 0x57 ('W'), A3 A2 A1 A0, D3 D2 D1 D0 (big-endian). Read: 0x52 ('R'), A3..A0.
- Responses. Write -> 0x4B ('K'). Read -> 4 bytes, MSB first. Unknown opcode -> 0x3F ('?'). Bus timeout -> 0x54 ('T').
- States: IDLE, ADDR, DATA, CSUM, BUS, SEND, WAITTX.
- IDLE:
  - rx_done with 'W' or 'R': latch opcode, byte_cnt=0, go ADDR.
  - rx_done with any other byte: load 0x3F, pulse err, go SEND.
- ADDR: each rx_done shifts the byte into addr from the LSB end. After the 4th byte: 'W' goes DATA; 'R' goes CSUM if the checksum option is compiled in, else BUS.
- DATA: same 4-byte shift into wdata, then CSUM or BUS.
- BUS:
  - Assert mem_req next cycle; hold mem_req, mem_addr, mem_we, mem_wdata stable until the cycle mem_ack is sampled high; deassert mem_req the following cycle.
  - Latch mem_rdata on mem_ack.
  - If mem_ack is not seen within BUS_TIMEOUT cycles: drop mem_req, pulse err, response 'T'.
  - Then go SEND.
- SEND: drive tx_data and tx_wr=1 for exactly one cycle, go WAITTX.
- WAITTX:
  - On tx_done: if bytes remain, go SEND with the next byte; else go IDLE.
  - Minimum gap between tx_wr pulses is therefore one full character time.
- Inter-byte timeout:
  - Applies in ADDR, DATA and CSUM.
  - Counter resets on each rx_done; on reaching TIMEOUT_CYCLES-1: pulse err, go IDLE, send no response.
- Bytes arriving in BUS, SEND or WAITTX are dropped silently. No error; this is not a protocol boundary.
- rx_done and timeout expiry in the same cycle: the byte wins and the counter restarts.
- mem_ack while mem_req=0: ignored.
- Address and data registers are 32-bit shift registers. A new command fully overwrites them; no carry-over between commands.
- Response byte counter is 3 bits: reads send 4 bytes, all other responses send 1.

Optional Feature:
- Macro UART_DBG_CHECKSUM_EN.
- Defined:
  - After the last address or data byte, go CSUM and expect one byte equal to the XOR of all preceding command bytes, opcode included.
  - Match: go BUS.
  - Mismatch: no bus access; respond 0x45 ('E'); pulse err.
- Undefined: the CSUM state is absent; commands carry no checksum byte.

Test Plan:
- Write: 57 00 00 10 00 DE AD BE EF -> one mem_req with mem_we=1, mem_addr=0x00001000, mem_wdata=0xDEADBEEF; ack after 3 cycles; response byte 0x4B.
- Read: 52 00 00 10 04, mem_rdata=0x12345678 on ack -> tx bytes 12 34 56 78, each tx_wr gated by the prior tx_done.
- Bad opcode 0x41 -> err pulse, response 0x3F, busy returns low after tx_done.
- Partial command 52 00 then silence for TIMEOUT_CYCLES (set to 100) -> err pulse at cycle 100, IDLE, no tx_wr; a following valid read completes normally.
- No mem_ack with BUS_TIMEOUT=16 -> mem_req drops after 16 cycles, err pulse, response 0x54. Separately, sys_rst asserted mid-BUS -> mem_req=0 immediately.
- With UART_DBG_CHECKSUM_EN: 52 00 00 00 08 5A passes (XOR=0x5A) and performs the read; the same command with checksum 0x00 -> response 0x45, no mem_req.

Source files
------------

// File: rtl/uart_dbg_responder.sv
// Serial debug command responder: decodes 'W'/'R' host commands into one 32-bit bus access and streams the reply bytes.
// Optional per-command XOR checksum byte is compiled in with `define UART_DBG_CHECKSUM_EN.
module uart_dbg_responder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter logic [15:0] BUS_TIMEOUT    = 16'd1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_Q = 8'h3F;
    localparam logic [7:0] RSP_T = 8'h54;

`ifdef UART_DBG_CHECKSUM_EN
    localparam logic [7:0] RSP_E = 8'h45;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, BUS, SEND, WAITTX} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, SEND, WAITTX} state_t;
`endif

    state_t      state_reg, state_next;
    logic        is_write_reg, is_write_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] resp_reg, resp_next;
    logic [2:0]  resp_cnt_reg, resp_cnt_next;
    logic [23:0] to_cnt_reg, to_cnt_next;
    logic [15:0] bus_cnt_reg, bus_cnt_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        tx_wr_reg, tx_wr_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        mem_we_reg, mem_we_next;
    logic        mem_req_reg, mem_req_next;
    logic        err_reg, err_next;
`ifdef UART_DBG_CHECKSUM_EN
    logic [7:0]  csum_reg, csum_next;
`endif
    logic        cmd_end;
    logic        start_bus;
    logic        in_cmd;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg     <= IDLE;
            is_write_reg  <= 1'b0;
            byte_cnt_reg  <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            resp_reg      <= '0;
            resp_cnt_reg  <= '0;
            to_cnt_reg    <= '0;
            bus_cnt_reg   <= '0;
            tx_data_reg   <= '0;
            tx_wr_reg     <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_req_reg   <= 1'b0;
            err_reg       <= 1'b0;
`ifdef UART_DBG_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            is_write_reg  <= is_write_next;
            byte_cnt_reg  <= byte_cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            resp_reg      <= resp_next;
            resp_cnt_reg  <= resp_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            bus_cnt_reg   <= bus_cnt_next;
            tx_data_reg   <= tx_data_next;
            tx_wr_reg     <= tx_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_we_reg    <= mem_we_next;
            mem_req_reg   <= mem_req_next;
            err_reg       <= err_next;
`ifdef UART_DBG_CHECKSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

`ifdef UART_DBG_CHECKSUM_EN
    assign in_cmd = (state_reg == ADDR) || (state_reg == DATA) || (state_reg == CSUM);
`else
    assign in_cmd = (state_reg == ADDR) || (state_reg == DATA);
`endif

    always_comb begin
        state_next     = state_reg;
        is_write_next  = is_write_reg;
        byte_cnt_next  = byte_cnt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        resp_next      = resp_reg;
        resp_cnt_next  = resp_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        bus_cnt_next   = bus_cnt_reg;
        tx_data_next   = tx_data_reg;
        tx_wr_next     = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_we_next    = mem_we_reg;
        mem_req_next   = mem_req_reg;
        err_next       = 1'b0;
`ifdef UART_DBG_CHECKSUM_EN
        csum_next      = csum_reg;
`endif
        cmd_end        = 1'b0;
        start_bus      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_done) begin
                    if (rx_data == OP_W || rx_data == OP_R) begin
                        is_write_next = (rx_data == OP_W);
                        byte_cnt_next = '0;
                        to_cnt_next   = '0;
                        state_next    = ADDR;
`ifdef UART_DBG_CHECKSUM_EN
                        csum_next     = rx_data;
`endif
                    end else begin
                        resp_next     = {RSP_Q, 24'h0};
                        resp_cnt_next = 3'd1;
                        err_next      = 1'b1;
                        state_next    = SEND;
                    end
                end
            end
            ADDR: begin
                if (rx_done) begin
                    addr_next     = {addr_reg[23:0], rx_data};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    to_cnt_next   = '0;
`ifdef UART_DBG_CHECKSUM_EN
                    csum_next     = csum_reg ^ rx_data;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        if (is_write_reg) begin
                            state_next = DATA;
                        end else begin
                            cmd_end = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_done) begin
                    wdata_next    = {wdata_reg[23:0], rx_data};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    to_cnt_next   = '0;
`ifdef UART_DBG_CHECKSUM_EN
                    csum_next     = csum_reg ^ rx_data;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        cmd_end = 1'b1;
                    end
                end
            end
`ifdef UART_DBG_CHECKSUM_EN
            CSUM: begin
                if (rx_done) begin
                    if (rx_data == csum_reg) begin
                        start_bus = 1'b1;
                    end else begin
                        resp_next     = {RSP_E, 24'h0};
                        resp_cnt_next = 3'd1;
                        err_next      = 1'b1;
                        state_next    = SEND;
                    end
                end
            end
`endif
            BUS: begin
                // An ack wins over a timeout landing in the same cycle.
                if (mem_ack && mem_req_reg) begin
                    mem_req_next = 1'b0;
                    state_next   = SEND;
                    if (mem_we_reg) begin
                        resp_next     = {RSP_K, 24'h0};
                        resp_cnt_next = 3'd1;
                    end else begin
                        resp_next     = mem_rdata;
                        resp_cnt_next = 3'd4;
                    end
                end else if (bus_cnt_reg == BUS_TIMEOUT - 16'd1) begin
                    mem_req_next  = 1'b0;
                    err_next      = 1'b1;
                    resp_next     = {RSP_T, 24'h0};
                    resp_cnt_next = 3'd1;
                    state_next    = SEND;
                end else begin
                    bus_cnt_next = bus_cnt_reg + 16'd1;
                end
            end
            SEND: begin
                tx_wr_next    = 1'b1;
                tx_data_next  = resp_reg[31:24];
                resp_next     = resp_reg << 8;
                resp_cnt_next = resp_cnt_reg - 3'd1;
                state_next    = WAITTX;
            end
            WAITTX: begin
                if (tx_done) begin
                    state_next = (resp_cnt_reg != 3'd0) ? SEND : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef UART_DBG_CHECKSUM_EN
        if (cmd_end) begin
            state_next = CSUM;
        end
`else
        if (cmd_end) begin
            start_bus = 1'b1;
        end
`endif

        // Bus fields are captured from the freshly shifted registers so the request rises one cycle after the last byte.
        if (start_bus) begin
            mem_req_next   = 1'b1;
            mem_addr_next  = addr_next & 32'hFFFF_FFFC;
            mem_wdata_next = wdata_next;
            mem_we_next    = is_write_reg;
            bus_cnt_next   = '0;
            state_next     = BUS;
        end

        if (in_cmd && !rx_done) begin
            if (to_cnt_reg == TIMEOUT_CYCLES - 24'd1) begin
                err_next   = 1'b1;
                state_next = IDLE;
            end else begin
                to_cnt_next = to_cnt_reg + 24'd1;
            end
        end
    end

    assign tx_data   = tx_data_reg;
    assign tx_wr     = tx_wr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_we    = mem_we_reg;
    assign mem_req   = mem_req_reg;
    assign err       = err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_dbg_responder.sv
// Self-checking bench for uart_dbg_responder: table of commands plus hand-written timeout, bus-timeout and reset sequences.
module tb_uart_dbg_responder;

    localparam logic [23:0] TO_CYC = 24'd100;
    localparam logic [15:0] BUS_TO = 16'd16;
    localparam logic [7:0]  OP_W   = 8'h57;
    localparam logic [7:0]  OP_R   = 8'h52;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;
    logic        err;

    uart_dbg_responder #(.TIMEOUT_CYCLES(TO_CYC), .BUS_TIMEOUT(BUS_TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_addr_q[$];
    logic        exp_we_q[$];
    logic [31:0] exp_wd_q[$];

    int n_tx = 0, n_req = 0, err_count = 0, last_hi = 0, cur_hi = 0;
    bit tx_busy = 1'b0;
    bit ack_enable = 1'b1;
    int ack_delay = 0;
    logic [31:0] rdata_val = 32'h0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        logic [31:0] exp_resp;
        int          exp_n;
        int          exp_err;
        int          exp_bus;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transmitter model: answers each tx_wr with tx_done a few cycles later.
    initial begin
        int gap;
        gap = 0;
        forever begin
            @(negedge sys_clk);
            tx_done = 1'b0;
            if (tx_wr) begin
                n_tx++;
                check("tx_wr_gated_by_tx_done", {31'h0, tx_busy}, 32'h0);
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %h, none expected", tx_data);
                end else begin
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
                end
                tx_busy = 1'b1;
                gap = 3;
            end else if (tx_busy) begin
                if (gap == 0) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                end else begin
                    gap--;
                end
            end
        end
    end

    // Memory model: checks each request against the scoreboard and acks after ack_delay cycles.
    initial begin
        bit req_prev, acked;
        int acnt;
        logic [31:0] held_addr;
        req_prev = 1'b0; acked = 1'b0; acnt = 0; held_addr = '0;
        forever begin
            @(negedge sys_clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                cur_hi++;
                if (!req_prev) begin
                    n_req++;
                    acked = 1'b0;
                    acnt = 0;
                    held_addr = mem_addr;
                    if (exp_addr_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL bus_unexpected: got request addr %h, none expected", mem_addr);
                    end else begin
                        logic we_e;
                        logic [31:0] wd_e;
                        we_e = exp_we_q.pop_front();
                        wd_e = exp_wd_q.pop_front();
                        check("mem_addr", mem_addr, exp_addr_q.pop_front());
                        check("mem_we", {31'h0, mem_we}, {31'h0, we_e});
                        if (we_e) check("mem_wdata", mem_wdata, wd_e);
                    end
                end else begin
                    check("mem_addr_stable", mem_addr, held_addr);
                end
                if (ack_enable && !acked) begin
                    if (acnt == ack_delay) begin
                        mem_ack = 1'b1;
                        mem_rdata = rdata_val;
                        acked = 1'b1;
                    end else begin
                        acnt++;
                    end
                end
            end else if (req_prev) begin
                last_hi = cur_hi;
                cur_hi = 0;
            end
            req_prev = mem_req;
        end
    end

    initial forever begin
        @(negedge sys_clk);
        if (err) err_count++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge sys_clk);
        @(negedge sys_clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge sys_clk);
        rx_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] b[$];
        b.push_back(op);
        if (op == OP_W || op == OP_R) begin
            for (int i = 3; i >= 0; i--) b.push_back(addr[8*i +: 8]);
            if (op == OP_W) for (int i = 3; i >= 0; i--) b.push_back(wdata[8*i +: 8]);
`ifdef UART_DBG_CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'h00;
                foreach (b[i]) x ^= b[i];
                b.push_back(x);
            end
`endif
        end
        foreach (b[i]) send_byte(b[i], 2);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge sys_clk);
            t++;
        end while ((busy || tx_busy) && t < 3000);
        if (t >= 3000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, required 0", name, busy, t);
        end
        repeat (2) @(negedge sys_clk);
        check({name, "_busy_low"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int e0, r0, t0;
        v = vecs[idx];
        e0 = err_count; r0 = n_req; t0 = n_tx;
        ack_enable = 1'b1;
        ack_delay = v.ack_dly;
        rdata_val = v.rdata;
        for (int i = v.exp_n - 1; i >= 0; i--) exp_tx.push_back(v.exp_resp[8*i +: 8]);
        if (v.exp_bus != 0) begin
            exp_addr_q.push_back(v.exp_addr);
            exp_we_q.push_back(v.op == OP_W);
            exp_wd_q.push_back(v.wdata);
        end
        send_cmd(v.op, v.addr, v.wdata);
        wait_idle("vec");
        check("vec_tx_count", n_tx - t0, v.exp_n);
        check("vec_req_count", n_req - r0, v.exp_bus);
        check("vec_err_count", err_count - e0, v.exp_err);
        check("vec_txq_drained", exp_tx.size(), 0);
        if (v.exp_bus != 0) check("vec_req_high_cycles", last_hi, v.ack_dly + 1);
        $display("vec %0d: op %02h addr %08h -> %0d tx bytes, %0d bus req, %0d err",
                 idx, v.op, v.addr, n_tx - t0, n_req - r0, err_count - e0);
    endtask

    initial begin
        int e0, r0, t0, t;

        vecs[0] = '{8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         3, 32'h0000_004B, 1, 0, 1, 32'h0000_1000};
        vecs[1] = '{8'h52, 32'h0000_1004, 32'h0,         32'h1234_5678, 2, 32'h1234_5678, 4, 0, 1, 32'h0000_1004};
        vecs[2] = '{8'h41, 32'h0,         32'h0,         32'h0,         0, 32'h0000_003F, 1, 1, 0, 32'h0};
        vecs[3] = '{8'h57, 32'h8000_0003, 32'h0123_4567, 32'h0,         0, 32'h0000_004B, 1, 0, 1, 32'h8000_0000};
        vecs[4] = '{8'h52, 32'hFFFF_FFFE, 32'h0,         32'hA5A5_0F0F, 7, 32'hA5A5_0F0F, 4, 0, 1, 32'hFFFF_FFFC};
        vecs[5] = '{8'h00, 32'h0,         32'h0,         32'h0,         0, 32'h0000_003F, 1, 1, 0, 32'h0};
        vecs[6] = '{8'h52, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 1, 32'hCAFE_F00D, 4, 0, 1, 32'h0000_0008};
        vecs[7] = '{8'h57, 32'h0000_0010, 32'h0000_0000, 32'h0,         5, 32'h0000_004B, 1, 0, 1, 32'h0000_0010};
        vecs[8] = '{8'h52, 32'h0000_0010, 32'h0,         32'h0000_0000, 0, 32'h0000_0000, 4, 0, 1, 32'h0000_0010};
        vecs[9] = '{8'hFF, 32'h0,         32'h0,         32'h0,         0, 32'h0000_003F, 1, 1, 0, 32'h0};

        repeat (3) @(negedge sys_clk);
        check("rst_tx_wr", {31'h0, tx_wr}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Partial command then silence: error after TIMEOUT_CYCLES, no reply, then a normal read.
        e0 = err_count; t0 = n_tx;
        send_byte(8'h52, 2);
        send_byte(8'h00, 2);
        t = 0;
        while (!err && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        check("rx_timeout_cycle", t, 100);
        repeat (3) @(negedge sys_clk);
        check("rx_timeout_err", err_count - e0, 1);
        check("rx_timeout_no_tx", n_tx - t0, 0);
        check("rx_timeout_busy_low", {31'h0, busy}, 32'h0);
        $display("rx timeout: err after %0d cycles", t);
        run_vec(1);

        // Bus never acks: request held BUS_TIMEOUT cycles, then 'T'.
        e0 = err_count;
        ack_enable = 1'b0;
        exp_addr_q.push_back(32'h0000_2000); exp_we_q.push_back(1'b0); exp_wd_q.push_back(32'h0);
        exp_tx.push_back(8'h54);
        send_cmd(OP_R, 32'h0000_2000, 32'h0);
        wait_idle("bus_to");
        check("bus_to_req_cycles", last_hi, 16);
        check("bus_to_err", err_count - e0, 1);
        check("bus_to_txq_drained", exp_tx.size(), 0);
        $display("bus timeout: mem_req high %0d cycles", last_hi);

        // Reset in the middle of a bus access drops mem_req at once.
        exp_addr_q.push_back(32'h0000_3000); exp_we_q.push_back(1'b0); exp_wd_q.push_back(32'h0);
        send_cmd(OP_R, 32'h0000_3000, 32'h0);
        t = 0;
        while (!mem_req && t < 100) begin
            @(negedge sys_clk);
            t++;
        end
        check("rst_bus_req_seen", {31'h0, mem_req}, 32'h1);
        repeat (3) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        check("rst_bus_req_drop", {31'h0, mem_req}, 32'h0);
        check("rst_bus_busy", {31'h0, busy}, 32'h0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        ack_enable = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("rst_bus_q_drained", exp_addr_q.size(), 0);
        $display("reset mid-bus: mem_req=%0b busy=%0b", mem_req, busy);
        run_vec(0);

`ifdef UART_DBG_CHECKSUM_EN
        // Wrong checksum: 'E', error pulse, no bus access.
        e0 = err_count; r0 = n_req;
        exp_tx.push_back(8'h45);
        send_byte(8'h52, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
        send_byte(8'h00, 2); send_byte(8'h08, 2); send_byte(8'h00, 2);
        wait_idle("csum_bad");
        check("csum_bad_no_req", n_req - r0, 0);
        check("csum_bad_err", err_count - e0, 1);
        check("csum_bad_txq_drained", exp_tx.size(), 0);
        $display("bad checksum: %0d bus req, %0d err", n_req - r0, err_count - e0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
